// File: rtl/gcd_bus_master.sv
// Bus initiator for the GPIO-emulated GCD peripheral: writes A1/A2, polls S until
// the busy bit clears, reads W, and returns the result on a valid/ready port.
module gcd_bus_master #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned MAX_POLLS     = 1024
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_gcd,
  output logic        res_err,
  output logic [15:0] res_polls,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  localparam logic [15:0] ADDR_A1     = 16'h00F8;
  localparam logic [15:0] ADDR_A2     = 16'h00FC;
  localparam logic [15:0] ADDR_W      = 16'h0100;
  localparam logic [15:0] ADDR_S      = 16'h0104;
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LIMIT  = 16'(MAX_POLLS);

  typedef enum logic [2:0] {S_IDLE, S_WR_A1, S_WR_A2, S_GAP, S_RD_S, S_RD_W, S_DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] op_b_q, op_b_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_gcd_q, res_gcd_d;
  logic        res_err_q, res_err_d;
  logic [15:0] res_polls_q, res_polls_d;
  logic [15:0] saddress_q, saddress_d;
  logic        srd_q, srd_d;
  logic        swr_q, swr_d;
  logic [31:0] sdata_out_q, sdata_out_d;
  logic [15:0] polls_inc;
  logic        is_wr;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    op_b_d      = op_b_q;
    cmd_ready_d = cmd_ready_q;
    res_valid_d = res_valid_q;
    res_gcd_d   = res_gcd_q;
    res_err_d   = res_err_q;
    res_polls_d = res_polls_q;
    saddress_d  = saddress_q;
    srd_d       = srd_q;
    swr_d       = swr_q;
    sdata_out_d = sdata_out_q;
    polls_inc   = (res_polls_q == '1) ? res_polls_q : res_polls_q + 16'd1;
    is_wr       = (state_q == S_WR_A1) || (state_q == S_WR_A2);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          res_polls_d = '0;
          res_gcd_d   = '0;
          res_err_d   = 1'b0;
          op_b_d      = cmd_b;
          // Zero operands would never terminate on the peripheral; answer locally.
          if (cmd_a == '0 || cmd_b == '0) begin
            state_d     = S_DONE;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
          end else begin
            state_d     = S_WR_A1;
            phase_d     = PH_SETUP;
            saddress_d  = ADDR_A1;
            sdata_out_d = cmd_a;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d    = S_RD_S;
          phase_d    = PH_SETUP;
          saddress_d = ADDR_S;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_STROBE;
            cnt_d   = STROBE_LAST;
            swr_d   = is_wr;
            srd_d   = !is_wr;
          end
          PH_STROBE: begin
            if (cnt_q == '0) begin
              phase_d = PH_HOLD;
              srd_d   = 1'b0;
              swr_d   = 1'b0;
            end else begin
              cnt_d = cnt_q - 16'd1;
            end
          end
          default: begin
            // End of HOLD: read data is sampled here and the next access chosen.
            case (state_q)
              S_WR_A1: begin
                state_d     = S_WR_A2;
                phase_d     = PH_SETUP;
                saddress_d  = ADDR_A2;
                sdata_out_d = op_b_q;
              end
              S_WR_A2: begin
                state_d = S_GAP;
                cnt_d   = GAP_LAST;
              end
              S_RD_S: begin
                res_polls_d = polls_inc;
                if (!sdata_in[3]) begin
                  state_d    = S_RD_W;
                  phase_d    = PH_SETUP;
                  saddress_d = ADDR_W;
                end else if (polls_inc >= POLL_LIMIT) begin
                  state_d     = S_DONE;
                  res_err_d   = 1'b1;
                  res_gcd_d   = '0;
                  res_valid_d = 1'b1;
                end else begin
                  state_d = S_GAP;
                  cnt_d   = GAP_LAST;
                end
              end
              default: begin
                state_d     = S_DONE;
                res_gcd_d   = sdata_in;
                res_err_d   = 1'b0;
                res_valid_d = 1'b1;
              end
            endcase
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      op_b_q      <= '0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_gcd_q   <= '0;
      res_err_q   <= 1'b0;
      res_polls_q <= '0;
      saddress_q  <= '0;
      srd_q       <= 1'b0;
      swr_q       <= 1'b0;
      sdata_out_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      op_b_q      <= op_b_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_gcd_q   <= res_gcd_d;
      res_err_q   <= res_err_d;
      res_polls_q <= res_polls_d;
      saddress_q  <= saddress_d;
      srd_q       <= srd_d;
      swr_q       <= swr_d;
      sdata_out_q <= sdata_out_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_gcd   = res_gcd_q;
  assign res_err   = res_err_q;
  assign res_polls = res_polls_q;
  assign saddress  = saddress_q;
  assign srd       = srd_q;
  assign swr       = swr_q;
  assign sdata_out = sdata_out_q;

endmodule

// File: tb/tb_gcd_bus_master.sv
// Bench for gcd_bus_master: behavioural GCD peripheral on the strobe bus, vector
// table, randomized commands against a reference model, and reset/backpressure sequences.
module tb_gcd_bus_master;

  localparam int SC   = 2;
  localparam int GAP  = 4;
  localparam int MAXP = 4;
  localparam int ACC  = SC + 2;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_gcd;
  logic        res_err;
  logic [15:0] res_polls;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in = '0;

  gcd_bus_master #(.STROBE_CYCLES(SC), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
    .clk(clk), .n_reset(n_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_gcd(res_gcd),
    .res_err(res_err), .res_polls(res_polls),
    .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_out(sdata_out), .sdata_in(sdata_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          busy;
    logic [31:0] g;
    logic        e;
    int          p;
    int          l;
  } vec_t;

  entry_t      bus_log[$];
  int          cfg_busy = 0;
  int          busy_left = 0;
  logic [31:0] per_a1 = '0;
  logic [31:0] per_a2 = '0;
  logic        dual_strobe = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Peripheral model: acts on strobe rising edges, S[3] busy for cfg_busy status reads.
  always @(posedge swr) begin
    bus_log.push_back('{wr: 1'b1, addr: saddress, data: sdata_out});
    if (saddress == 16'h00F8) per_a1 = sdata_out;
    else if (saddress == 16'h00FC) begin
      per_a2 = sdata_out;
      busy_left = cfg_busy;
    end
  end

  always @(posedge srd) begin
    logic [31:0] v;
    v = '0;
    if (saddress == 16'h0104) begin
      v = (busy_left > 0) ? 32'h8 : 32'h0;
      if (busy_left > 0) busy_left--;
    end else if (saddress == 16'h0100) begin
      v = gcd_ref(per_a1, per_a2);
    end
    sdata_in = v;
    bus_log.push_back('{wr: 1'b0, addr: saddress, data: v});
  end

  always @(srd or swr) if (srd && swr) dual_strobe = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_outs"},
          {cmd_ready, res_valid, res_err, srd, swr, res_polls, saddress},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
    check({nm, "_data"}, {res_gcd, sdata_out}, 64'h0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("issue_ready", (k < 100), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake(input string nm);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({nm, "_release"}, {cmd_ready, res_valid}, {1'b1, 1'b0});
  endtask

  task automatic run_txn(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input int busy, input logic [31:0] eg, input logic ee,
                         input int ep, input int el);
    entry_t exp_log[$];
    int     lat;
    bus_log.delete();
    cfg_busy = busy;
    issue(a, b);
    wait_valid(lat);
    check({nm, "_valid"}, res_valid, 1);
    check({nm, "_gcd"}, res_gcd, eg);
    check({nm, "_err"}, res_err, ee);
    check({nm, "_polls"}, res_polls, ep);
    check({nm, "_latency"}, lat, el);
    check({nm, "_cmd_ready"}, cmd_ready, 0);
    if (a != 0 && b != 0) begin
      exp_log.push_back('{wr: 1'b1, addr: 16'h00F8, data: a});
      exp_log.push_back('{wr: 1'b1, addr: 16'h00FC, data: b});
      for (int i = 0; i < ep; i++)
        exp_log.push_back('{wr: 1'b0, addr: 16'h0104, data: (i < busy) ? 32'h8 : 32'h0});
      if (!ee) exp_log.push_back('{wr: 1'b0, addr: 16'h0100, data: eg});
    end
    check({nm, "_log_len"}, bus_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
      check($sformatf("%s_log%0d", nm, i), 64'(bus_log[i]), 64'(exp_log[i]));
    handshake(nm);
  endtask

  initial begin
    vec_t        tbl[8];
    logic [31:0] a, b, g, eg;
    logic        zero, to, ee;
    int          busy, ep, el, n, ok, lat, k;

    tbl[0] = '{32'd48, 32'd18, 1, 32'd6, 1'b0, 2, 28};
    tbl[1] = '{32'd48, 32'd18, 0, 32'd6, 1'b0, 1, 20};
    tbl[2] = '{32'd0, 32'd5, 0, 32'd0, 1'b1, 0, 0};
    tbl[3] = '{32'd5, 32'd0, 0, 32'd0, 1'b1, 0, 0};
    tbl[4] = '{32'd100, 32'd75, 1000, 32'd0, 1'b1, 4, 40};
    tbl[5] = '{32'd17, 32'd13, 3, 32'd1, 1'b0, 4, 44};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b0, 1, 20};
    tbl[7] = '{32'd1024, 32'd4096, 2, 32'd1024, 1'b0, 3, 36};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].busy,
              tbl[i].g, tbl[i].e, tbl[i].p, tbl[i].l);

    for (int i = 0; i < 20; i++) begin
      g = $urandom_range(1, 60);
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : g * $urandom_range(1, 5000);
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : g * $urandom_range(1, 5000);
      busy = $urandom_range(0, 5);
      zero = (a == 0) || (b == 0);
      to   = !zero && (busy >= MAXP);
      ee   = zero || to;
      ep   = zero ? 0 : (to ? MAXP : busy + 1);
      eg   = ee ? 32'd0 : gcd_ref(a, b);
      el   = zero ? 0 : 2 * ACC + ep * (GAP + ACC) + (ee ? 0 : ACC);
      run_txn($sformatf("rnd%0d", i), a, b, busy, eg, ee, ep, el);
    end

    // Backpressure: result held, second command ignored until release.
    bus_log.delete();
    cfg_busy = 0;
    issue(32'd7, 32'd7);
    wait_valid(lat);
    check("bp_latency", lat, 20);
    cmd_valid = 1'b1;
    cmd_a = 32'd9;
    cmd_b = 32'd6;
    n = bus_log.size();
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(res_valid && res_gcd == 32'd7 && !cmd_ready)) ok = 0;
    end
    check("bp_hold", ok, 1);
    check("bp_no_new_strobe", bus_log.size(), n);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_ready_after", {cmd_ready, res_valid}, {1'b1, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_second_start", {cmd_ready, saddress, sdata_out, swr}, {1'b0, 16'h00F8, 32'd9, 1'b0});
    wait_valid(lat);
    check("bp_second_gcd", {res_valid, res_err, res_gcd}, {1'b1, 1'b0, 32'd3});
    handshake("bp2");

    // Reset during the A2 strobe: strobe must drop without a clock edge.
    bus_log.delete();
    issue(32'd21, 32'd14);
    k = 0;
    while (!(swr && saddress == 16'h00FC) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("midop_reach_a2", (k < 50), 1);
    #1 n_reset = 1'b1;
    #1 check_reset_outputs("midop_async");
    n = bus_log.size();
    repeat (3) @(negedge clk);
    check("midop_no_edges", bus_log.size(), n);
    check_reset_outputs("midop_held");
    n_reset = 1'b0;
    run_txn("post_reset", 32'd9, 32'd6, 1, 32'd3, 1'b0, 2, 28);

    check("no_dual_strobe", dual_strobe, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
